hb_decim_mc: RTL and testbench
==============================

Name: hb_decim_mc

Overview:
- Parametrised multi-channel half-band decimate-by-2 filter. Successor to the fixed 15-tap, single-channel half-band stage in the DDC decimation chain.
- NCH channels share one input strobe. A single time-shared multiplier performs serial symmetric MACs.
- Adds runtime-loadable tap count up to NCOEF, convergent-free round-half-up, output saturation, bypass mode and overrun detection.

Parameters:
- IN_W, 18, input sample width per channel (signed).
- COE_W, 16, coefficient width, signed Q1.(COE_W-1).
- OUT_W, 22, output width per channel (signed); OUT_W > IN_W.
- NCOEF, 4, unique non-zero non-centre coefficients. Filter length L = 4*NCOEF-1.
- NCH, 2, channel count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- coef_shift  in  1  shift coef_in into the shadow coefficient chain.
- coef_in  in  COE_W  coefficient word.
- config_sync  in  1  copy shadow coefficients to active set.
- bypass  in  1  1 = decimate without filtering.
- rnd_en  in  1  1 = round-half-up, 0 = truncate.
- data_in  in  NCH*IN_W  channel k at bits [k*IN_W +: IN_W].
- data_in_flag  in  1  sample strobe, all channels.
- hb_flag  out  1  one-cycle output valid.
- hb_result  out  NCH*OUT_W  channel k at [k*OUT_W +: OUT_W].
- busy  out  1  MAC sequencer not IDLE.
- ovf  out  1  sticky overrun.

Behaviour:
- Reset: all of the following clear to 0: delay lines, shadow and active coefficients, FSM=IDLE, phase=0, hb_flag, hb_result, busy, ovf, sync_pending.
- Coefficient load:
  - coef_shift shifts coef_in into shadow chain, newest at sh[0].
  - Load order is outermost first, so after NCOEF shifts c[i] = sh[NCOEF-1-i].
  - config_sync copies shadow to active when FSM=IDLE. Otherwise it sets sync_pending, and the copy happens on the first IDLE cycle.
- Sample acceptance:
  - data_in_flag with FSM=IDLE: each channel delay line shifts (d[0] = newest) and phase toggles.
  - data_in_flag with FSM≠IDLE: sample dropped, phase unchanged, ovf set (cleared only by rst).
- Trigger: an accepted sample with phase=1 before toggle starts a computation. The 2nd, 4th, ... accepted samples after reset produce outputs.
- FSM states IDLE -> MAC -> CTR -> OUT -> IDLE:
  - MAC: NCH*NCOEF cycles, channel-major. Cycle (k,i) forms pre-add p = d_k[2i] + d_k[L-1-2i] (IN_W+1 bits, no halving), then acc_k += p*c[i].
  - CTR: acc_k += d_k[2*NCOEF-1] << (COE_W-1), i.e. the 0.5 centre tap.
  - OUT: for each k, SHIFT = IN_W+COE_W-OUT_W. Add 2^(SHIFT-1) if rnd_en, arithmetic shift right by SHIFT, saturate to the OUT_W signed range. Register the result to hb_result and pulse hb_flag.
- Accumulator width: ACC_W = IN_W+COE_W+2+clog2(NCOEF). Full precision, no intermediate truncation.
- Latency: trigger strobe sampled at edge t gives hb_flag high for exactly the cycle following edge t+NCH*NCOEF+2. Defaults: 11 cycles. Minimum strobe spacing without overrun is NCH*NCOEF+3.
- Bypass (sampled at trigger):
  - FSM goes IDLE -> OUT directly.
  - hb_result_k = d_k[0] sign-extended, << (OUT_W-IN_W-1). hb_flag follows the trigger after 2 edges.
- hb_result holds its value between flags.
- rst mid-computation aborts with no flag.
- Simultaneous config_sync and trigger strobe in IDLE: coefficients update first, and the computation uses the new set.

Decomposition:
- Shared package hb_pkg:
  - clog2 function.
  - FSM state encoding.
  - ACC_W/SHIFT derivation functions.
  - sat_round function (round, shift, saturate).
- One natural sub-module: hb_coef_bank (shadow chain, active set, sync_pending deferral, coefficient read mux by index i).

Test Plan:
- Coefficients c = {0x0100, 0xFC00, 0x0A00, 0x2000}, rnd_en=1, ch0 impulse 1000 as 2nd sample, then zeros at spacing 12:
  - Successive ch0 outputs 63, -250, 625, 2000, 2000, 625, -250, 63, then 0.
  - ch1 stays 0.
  - hb_flag 11 cycles after each trigger.
- Same coefficients, impulse 1000 as 1st sample -> outputs 0, 0, 0, 8000 (centre tap), 0, ...
- DC input 0x1FFFF on both channels with c = all 0x7FFF, rnd_en=0 -> hb_result saturates to 0x1FFFFF; -0x20000 saturates to 0x200000.
- Strobes at spacing 5 -> second triggering-phase strobe dropped, ovf=1 and stays 1, phase unaffected. Only rst clears ovf.
- config_sync pulsed during MAC -> current output uses old set. New set is applied at IDLE, and the next output reflects it.
- bypass=1, samples 100, 200 on ch0 -> hb_result_ch0 = 200<<3 = 1600, hb_flag 2 cycles after the strobe.
- rst asserted mid-MAC -> hb_flag never pulses, all outputs 0, and the next computation after release is correct.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared definitions for the multi-channel half-band decimator.
//   - hb_state_t   : MAC sequencer state encoding
//   - clog2        : ceiling log2 for elaboration-time sizing
//   - acc_width    : full-precision accumulator width
//   - shift_width  : right shift that maps the accumulator onto the output
//   - sat_round    : optional round-half-up, arithmetic shift, saturation
package hb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_CTR  = 2'd2,
    ST_OUT  = 2'd3
  } hb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Products are (IN_W+1)+COE_W bits; NCOEF of them plus the centre tap
  // need clog2(NCOEF) plus one more bit of growth.
  function automatic int acc_width(input int in_w, input int coe_w, input int ncoef);
    return in_w + coe_w + 2 + clog2(ncoef);
  endfunction

  function automatic int shift_width(input int in_w, input int coe_w, input int out_w);
    return in_w + coe_w - out_w;
  endfunction

  // Operates on a 64-bit container so that one function serves every
  // parameterisation; callers sign-extend in and truncate out.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int                 shift,
                                                   input int                 out_w,
                                                   input logic               rnd);
    logic signed [63:0] v;
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    v = acc;
    if (rnd) v = v + (64'sd1 <<< (shift - 1));
    v    = v >>> shift;
    maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (out_w - 1));
    if (v > maxv) return maxv;
    if (v < minv) return minv;
    return v;
  endfunction

endpackage

// File: rtl/hb_coef_bank.sv
// Coefficient storage for the half-band decimator.
//   clk, rst     : clock, asynchronous active-low reset
//   coef_shift   : shift coef_in into the shadow chain (newest at sh[0])
//   coef_in      : coefficient word, signed Q1.(COE_W-1)
//   config_sync  : copy shadow to active; deferred until idle is high
//   idle         : sequencer is idle, active set may be replaced
//   idx          : tap index i being multiplied
//   coef         : active coefficient c[idx]
module hb_coef_bank
  import hb_pkg::*;
#(
  parameter int COE_W = 16,
  parameter int NCOEF = 4,
  parameter int IDX_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_shift,
  input  logic [COE_W-1:0]        coef_in,
  input  logic                    config_sync,
  input  logic                    idle,
  input  logic [IDX_W-1:0]        idx,
  output logic signed [COE_W-1:0] coef
);

  logic signed [COE_W-1:0] sh  [NCOEF];
  logic signed [COE_W-1:0] act [NCOEF];
  logic                    sync_pending;
  logic                    do_copy;

  // A sync requested while busy is remembered and applied on the first
  // idle cycle, so a running computation never sees a mixed set.
  assign do_copy = (config_sync | sync_pending) & idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pending <= 1'b0;
      for (int j = 0; j < NCOEF; j++) begin
        sh[j]  <= '0;
        act[j] <= '0;
      end
    end else begin
      if (coef_shift) begin
        sh[0] <= $signed(coef_in);
        for (int j = 1; j < NCOEF; j++) sh[j] <= sh[j-1];
      end
      if (do_copy) begin
        // Loaded outermost first, so the oldest word is c[0].
        for (int j = 0; j < NCOEF; j++) act[j] <= sh[NCOEF-1-j];
        sync_pending <= 1'b0;
      end else if (config_sync) begin
        sync_pending <= 1'b1;
      end
    end
  end

  assign coef = act[idx];

endmodule

// File: rtl/hb_decim_mc.sv
// Multi-channel half-band decimate-by-2 filter with one shared multiplier.
//   clk, rst      : clock, asynchronous active-low reset
//   coef_shift    : shift coef_in into the shadow coefficient chain
//   coef_in       : coefficient word
//   config_sync   : copy shadow coefficients to the active set
//   bypass        : decimate without filtering (sampled at trigger)
//   rnd_en        : 1 = round-half-up, 0 = truncate
//   data_in       : NCH samples, channel k at [k*IN_W +: IN_W]
//   data_in_flag  : sample strobe for all channels
//   hb_flag       : one-cycle output valid
//   hb_result     : NCH results, channel k at [k*OUT_W +: OUT_W]
//   busy          : sequencer not idle
//   ovf           : sticky, a strobe arrived while busy
module hb_decim_mc
  import hb_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int COE_W = 16,
  parameter int OUT_W = 22,
  parameter int NCOEF = 4,
  parameter int NCH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   coef_shift,
  input  logic [COE_W-1:0]       coef_in,
  input  logic                   config_sync,
  input  logic                   bypass,
  input  logic                   rnd_en,
  input  logic [NCH*IN_W-1:0]    data_in,
  input  logic                   data_in_flag,
  output logic                   hb_flag,
  output logic [NCH*OUT_W-1:0]   hb_result,
  output logic                   busy,
  output logic                   ovf
);

  localparam int L       = 4*NCOEF - 1;
  localparam int CTR_TAP = 2*NCOEF - 1;
  localparam int ACC_W   = acc_width(IN_W, COE_W, NCOEF);
  localparam int SHIFT   = shift_width(IN_W, COE_W, OUT_W);
  localparam int IDX_W   = (clog2(NCOEF) < 1) ? 1 : clog2(NCOEF);
  localparam int CH_W    = (clog2(NCH) < 1) ? 1 : clog2(NCH);
  localparam int DI_W    = (clog2(L) < 1) ? 1 : clog2(L);
  localparam int PRE_W   = IN_W + 1;
  localparam int PROD_W  = PRE_W + COE_W;
  localparam int BYP_SH  = OUT_W - IN_W - 1;

  hb_state_t state;
  hb_state_t nxt;

  logic                    phase;
  logic                    byp_mode;
  logic [IDX_W-1:0]        tap;
  logic [CH_W-1:0]         ch;
  logic signed [IN_W-1:0]  dly [NCH][L];
  logic signed [ACC_W-1:0] acc [NCH];
  logic signed [COE_W-1:0] coef;

  logic                    idle;
  logic                    accept;
  logic                    trig;
  logic                    mac_last;
  logic [DI_W-1:0]         ia;
  logic [DI_W-1:0]         ib;
  logic signed [PRE_W-1:0] pre;
  logic signed [PROD_W-1:0] prod;

  assign idle     = (state == ST_IDLE);
  assign accept   = data_in_flag & idle;
  // Every second accepted sample starts a computation (decimate by 2).
  assign trig     = accept & phase;
  assign mac_last = (ch == CH_W'(NCH-1)) && (tap == IDX_W'(NCOEF-1));
  assign busy     = ~idle;

  hb_coef_bank #(
    .COE_W (COE_W),
    .NCOEF (NCOEF),
    .IDX_W (IDX_W)
  ) u_coef (
    .clk         (clk),
    .rst         (rst),
    .coef_shift  (coef_shift),
    .coef_in     (coef_in),
    .config_sync (config_sync),
    .idle        (idle),
    .idx         (tap),
    .coef        (coef)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (trig) nxt = bypass ? ST_OUT : ST_MAC;
      ST_MAC:  if (mac_last) nxt = ST_CTR;
      ST_CTR:  nxt = ST_OUT;
      ST_OUT:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Symmetric pre-add: taps 2i and L-1-2i share coefficient c[i].
  always_comb begin
    ia   = DI_W'({tap, 1'b0});
    ib   = DI_W'(L-1) - ia;
    pre  = PRE_W'(dly[ch][ia]) + PRE_W'(dly[ch][ib]);
    prod = PROD_W'(pre) * PROD_W'(coef);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= 1'b0;
      ovf       <= 1'b0;
      hb_flag   <= 1'b0;
      hb_result <= '0;
      byp_mode  <= 1'b0;
      tap       <= '0;
      ch        <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc[k] <= '0;
        for (int j = 0; j < L; j++) dly[k][j] <= '0;
      end
    end else begin
      hb_flag <= 1'b0;
      if (data_in_flag && !idle) ovf <= 1'b1;

      if (accept) begin
        phase <= ~phase;
        for (int k = 0; k < NCH; k++) begin
          dly[k][0] <= $signed(data_in[k*IN_W +: IN_W]);
          for (int j = 1; j < L; j++) dly[k][j] <= dly[k][j-1];
        end
      end

      case (state)
        ST_IDLE: begin
          if (trig) begin
            byp_mode <= bypass;
            tap      <= '0;
            ch       <= '0;
            for (int k = 0; k < NCH; k++) acc[k] <= '0;
          end
        end
        // MAC: one (channel, tap) product per cycle, channel-major.
        ST_MAC: begin
          acc[ch] <= acc[ch] + ACC_W'(prod);
          if (tap == IDX_W'(NCOEF-1)) begin
            tap <= '0;
            ch  <= ch + CH_W'(1);
          end else begin
            tap <= tap + IDX_W'(1);
          end
        end
        // CTR: centre tap is exactly 0.5, a shift rather than a multiply.
        ST_CTR: begin
          for (int k = 0; k < NCH; k++)
            acc[k] <= acc[k] + (ACC_W'(dly[k][CTR_TAP]) <<< (COE_W-1));
        end
        // OUT: scale to output width and present the result.
        ST_OUT: begin
          hb_flag <= 1'b1;
          for (int k = 0; k < NCH; k++)
            hb_result[k*OUT_W +: OUT_W] <= byp_mode
              ? (OUT_W'(dly[k][0]) <<< BYP_SH)
              : OUT_W'(sat_round(64'(acc[k]), SHIFT, OUT_W, rnd_en));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_decim_mc.sv
module tb_hb_decim_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_shift;
  logic [15:0] coef_in;
  logic        config_sync;
  logic        bypass;
  logic        rnd_en;
  logic [35:0] data_in;
  logic        data_in_flag;
  logic        hb_flag;
  logic [43:0] hb_result;
  logic        busy;
  logic        ovf;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int s0;
    int s1;
    bit chk;
    int e0;
    int e1;
  } vec_t;

  vec_t tbl[$];

  hb_decim_mc dut (
    .clk          (clk),
    .rst          (rst),
    .coef_shift   (coef_shift),
    .coef_in      (coef_in),
    .config_sync  (config_sync),
    .bypass       (bypass),
    .rnd_en       (rnd_en),
    .data_in      (data_in),
    .data_in_flag (data_in_flag),
    .hb_flag      (hb_flag),
    .hb_result    (hb_result),
    .busy         (busy),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  function automatic longint res(input int k);
    logic signed [21:0] v;
    v = hb_result[k*22 +: 22];
    return longint'(v);
  endfunction

  task automatic add(input int s0, input int s1, input bit chk, input int e0, input int e1);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.chk = chk; v.e0 = e0; v.e1 = e1;
    tbl.push_back(v);
  endtask

  // Called on a negedge; returns on the next negedge (c = 1 after the strobe).
  task automatic pulse(input int s0, input int s1);
    data_in      = {18'(s1), 18'(s0)};
    data_in_flag = 1'b1;
    @(negedge clk);
    data_in_flag = 1'b0;
  endtask

  // lat = negedge index (counted from the strobe) at which hb_flag is seen, 0 if never.
  task automatic wait_flag(input int c0, input int maxc, output int lat);
    lat = 0;
    for (int c = c0; c <= maxc; c++) begin
      if (hb_flag) begin
        lat = c;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic feed(input int s0, input int s1, input int n);
    for (int i = 0; i < n; i++) begin
      pulse(s0, s1);
      repeat (11) @(negedge clk);
    end
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3, input bit sync);
    int cs [4];
    cs = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      coef_in    = 16'(cs[i]);
      coef_shift = 1'b1;
      @(negedge clk);
      coef_shift = 1'b0;
    end
    if (sync) begin
      config_sync = 1'b1;
      @(negedge clk);
      config_sync = 1'b0;
    end
  endtask

  // One strobe at spacing 12; checks either the result or the absence of a flag.
  task automatic step(input int r, input vec_t v);
    int lat;
    int seen;
    pulse(v.s0, v.s1);
    if (v.chk) begin
      wait_flag(1, 20, lat);
      check($sformatf("row%0d_latency", r), lat, 11);
      check($sformatf("row%0d_ch0", r), res(0), v.e0);
      check($sformatf("row%0d_ch1", r), res(1), v.e1);
      @(negedge clk);
      check($sformatf("row%0d_flag_width", r), hb_flag, 0);
      for (int c = lat + 1; c < 12; c++) @(negedge clk);
    end else begin
      seen = 0;
      for (int c = 1; c < 12; c++) begin
        if (hb_flag) seen++;
        @(negedge clk);
      end
      check($sformatf("row%0d_no_flag", r), seen, 0);
    end
  endtask

  initial begin
    int   ea0 [8];
    int   eb0 [8];
    int   eb1 [8];
    int   lat;
    int   seen;
    vec_t v;

    rst = 1'b0; coef_shift = 1'b0; coef_in = '0; config_sync = 1'b0;
    bypass = 1'b0; rnd_en = 1'b1; data_in = '0; data_in_flag = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_flag", hb_flag, 0);
    check("reset_result", longint'(hb_result), 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b1;
    @(negedge clk);

    load_coefs(16'h0100, 16'hFC00, 16'h0A00, 16'h2000, 1'b1);

    // Impulse on ch0 as the 2nd sample: impulse response at even taps.
    ea0 = '{-250, 625, 2000, 2000, 625, -250, 63, 0};
    add(0, 0, 1'b0, 0, 0);
    add(1000, 0, 1'b1, 63, 0);
    for (int i = 0; i < 8; i++) begin
      add(0, 0, 1'b0, 0, 0);
      add(0, 0, 1'b1, ea0[i], 0);
    end
    // ch0 impulse as 1st sample (odd taps, centre only), ch1 -1000 as 2nd.
    eb0 = '{0, 0, 8000, 0, 0, 0, 0, 0};
    eb1 = '{250, -625, -2000, -2000, -625, 250, -62, 0};
    add(1000, 0, 1'b0, 0, 0);
    add(0, -1000, 1'b1, 0, -62);
    for (int i = 0; i < 8; i++) begin
      add(0, 0, 1'b0, 0, 0);
      add(0, 0, 1'b1, eb0[i], eb1[i]);
    end
    for (int r = 0; r < tbl.size(); r++) step(r, tbl[r]);

    // Bypass: latest sample, shifted left by 3.
    bypass = 1'b1;
    pulse(100, 0);
    repeat (3) @(negedge clk);
    pulse(200, -5);
    wait_flag(1, 10, lat);
    check("bypass_latency", lat, 2);
    check("bypass_ch0", res(0), 1600);
    check("bypass_ch1", res(1), -40);
    repeat (3) @(negedge clk);
    bypass = 1'b0;
    feed(0, 0, 16);

    // Saturation at full-scale DC, truncating.
    rnd_en = 1'b0;
    load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    feed(131071, 131071, 15);
    v.s0 = 131071; v.s1 = 131071; v.chk = 1'b1; v.e0 = 2097151; v.e1 = 2097151;
    step(100, v);
    feed(-131072, -131072, 15);
    v.s0 = -131072; v.s1 = -131072; v.e0 = -2097152; v.e1 = -2097152;
    step(101, v);
    feed(0, 0, 16);
    rnd_en = 1'b1;
    load_coefs(16'h0100, 16'hFC00, 16'h0A00, 16'h2000, 1'b1);

    // Overrun: strobes at spacing 5.
    pulse(0, 0);
    repeat (4) @(negedge clk);
    pulse(1000, 0);
    repeat (3) @(negedge clk);
    check("ovr_busy", busy, 1);
    check("ovr_ovf_before", ovf, 0);
    @(negedge clk);
    pulse(5000, 0);
    check("ovr_ovf_set", ovf, 1);
    repeat (4) @(negedge clk);
    pulse(7000, 0);
    check("ovr_flag", hb_flag, 1);
    check("ovr_ch0", res(0), 63);
    repeat (4) @(negedge clk);
    pulse(0, 0);
    repeat (4) @(negedge clk);
    pulse(0, 0);
    wait_flag(1, 20, lat);
    check("ovr_next_latency", lat, 11);
    check("ovr_next_ch0", res(0), -250);
    check("ovr_sticky", ovf, 1);
    repeat (2) @(negedge clk);
    feed(0, 0, 16);

    // config_sync during MAC: old set now, new set on the next output.
    load_coefs(16'h0200, 16'h0400, 16'h0000, 16'h0000, 1'b0);
    pulse(0, 0);
    repeat (11) @(negedge clk);
    pulse(1000, 0);
    @(negedge clk);
    config_sync = 1'b1;
    @(negedge clk);
    config_sync = 1'b0;
    wait_flag(3, 20, lat);
    check("sync_latency", lat, 11);
    check("sync_old_set", res(0), 63);
    @(negedge clk);
    pulse(0, 0);
    check("sync_hold", res(0), 63);
    repeat (11) @(negedge clk);
    pulse(0, 0);
    wait_flag(1, 20, lat);
    check("sync_new_latency", lat, 11);
    check("sync_new_set", res(0), 250);
    repeat (2) @(negedge clk);

    // Reset mid-MAC aborts the computation.
    pulse(0, 0);
    repeat (11) @(negedge clk);
    pulse(500, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_flag", hb_flag, 0);
    check("rst_mid_result", longint'(hb_result), 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (hb_flag) seen++;
    end
    check("rst_no_flag", seen, 0);
    load_coefs(16'h0100, 16'hFC00, 16'h0A00, 16'h2000, 1'b1);
    pulse(0, 0);
    repeat (11) @(negedge clk);
    pulse(1000, 0);
    wait_flag(1, 20, lat);
    check("rst_after_latency", lat, 11);
    check("rst_after_ch0", res(0), 63);
    check("rst_after_ch1", res(1), 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
